snn_lif_layer: RTL and testbench

Parametrised layer of leaky integrate-and-fire (LIF) neurons that succeeds the fixed 16-in/8-out SNN core behind the IO-pad wrapper. On each `step` pulse the block samples an N_IN-bit input spike vector. It then updates N_OUT neurons one per cycle against a writable signed weight memory and publishes the new N_OUT-bit output spike vector. Neuron state is time-multiplexed through a single accumulate/leak/fire datapath, so successive layers can be chained or a layer can be driven directly from pads.

---
 rtl/snn_lif_layer.sv | 196 +++++++++++++++++++
 tb/tb_snn_lif_layer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_lif_layer.sv
// Time-multiplexed layer of leaky integrate-and-fire neurons with a writable signed weight memory.
// Optional refractory counters are built when SNN_REFRACTORY_EN is defined.
module snn_lif_layer #(
  parameter int unsigned N_IN       = 16,
  parameter int unsigned N_OUT      = 8,
  parameter int unsigned WW         = 8,
  parameter int unsigned PW         = 16,
  parameter int unsigned LEAK_SHIFT = 4,
  parameter int unsigned REFRAC     = 2,
  localparam int unsigned AW = (N_OUT * N_IN > 1) ? $clog2(N_OUT * N_IN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic [N_IN-1:0]      in_signal,
  input  logic [PW-2:0]        thresh,
  input  logic                 wt_we,
  input  logic [AW-1:0]        wt_addr,
  input  logic [WW-1:0]        wt_data,
  output logic [N_OUT-1:0]     out_spk,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int unsigned IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned SW = WW + $clog2(N_IN) + 1;
  localparam int unsigned XW = ((PW > SW) ? PW : SW) + 2;
  localparam logic [AW:0] NWORDS = (AW + 1)'(N_OUT * N_IN);
  localparam logic signed [XW-1:0] VMAX = {{(XW - PW + 1){1'b0}}, {(PW - 1){1'b1}}};
  localparam logic signed [XW-1:0] VMIN = {{(XW - PW + 1){1'b1}}, {(PW - 1){1'b0}}};

  typedef enum logic [0:0] {StIdle, StUpdate} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic [N_OUT-1:0]      out_spk_q, out_spk_d;
  logic [N_OUT-1:0]      shadow_q, shadow_d;
  logic [N_IN-1:0]       spk_in_q, spk_in_d;
  logic signed [PW-1:0]  pot_q [N_OUT];
  logic                  pot_we;

  logic signed [WW-1:0]  wmem [N_OUT * N_IN];
  logic [AW-1:0]         raddr;
  logic signed [SW-1:0]  sum;
  logic signed [PW-1:0]  v;
  logic signed [XW-1:0]  v_raw;
  logic signed [PW-1:0]  v_next;
  logic                  fire;
  logic                  new_bit;
  logic signed [PW-1:0]  new_pot;

  // Weight memory is deliberately not reset; a same-cycle write is seen by the next read.
  always_ff @(posedge clk) begin
    if (wt_we && ({1'b0, wt_addr} < NWORDS)) begin
      wmem[wt_addr] <= wt_data;
    end
  end

  always_comb begin
    sum   = '0;
    raddr = '0;
    for (int i = 0; i < N_IN; i++) begin
      raddr = AW'(idx_q * N_IN + i);
      if (spk_in_q[i]) begin
        sum = sum + SW'(wmem[raddr]);
      end
    end
  end

  always_comb begin
    v     = pot_q[idx_q];
    v_raw = XW'(v) - XW'(v >>> LEAK_SHIFT) + XW'(sum);
    if (v_raw > VMAX) begin
      v_next = VMAX[PW-1:0];
    end else if (v_raw < VMIN) begin
      v_next = VMIN[PW-1:0];
    end else begin
      v_next = v_raw[PW-1:0];
    end
    fire = (v_next >= $signed({1'b0, thresh}));
  end

`ifdef SNN_REFRACTORY_EN
  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [RW-1:0] ref_q [N_OUT];
  logic [RW-1:0] new_ref;

  // A refractory neuron ignores both input and leak and holds its potential at zero.
  always_comb begin
    new_bit = 1'b0;
    new_pot = '0;
    new_ref = '0;
    if (ref_q[idx_q] != '0) begin
      new_ref = ref_q[idx_q] - 1'b1;
    end else if (fire) begin
      new_bit = 1'b1;
      new_ref = RW'(REFRAC);
    end else begin
      new_pot = v_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < N_OUT; n++) begin
        ref_q[n] <= '0;
      end
    end else if (pot_we) begin
      ref_q[idx_q] <= new_ref;
    end
  end
`else
  always_comb begin
    new_bit = fire;
    new_pot = fire ? '0 : v_next;
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    out_spk_d = out_spk_q;
    shadow_d  = shadow_q;
    spk_in_d  = spk_in_q;
    pot_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (step) begin
          spk_in_d = in_signal;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = StUpdate;
        end
      end
      StUpdate: begin
        if (step) begin
          overrun_d = 1'b1;
        end
        pot_we          = 1'b1;
        shadow_d[idx_q] = new_bit;
        if (idx_q == IW'(N_OUT - 1)) begin
          out_spk_d = shadow_d;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          idx_d     = '0;
          state_d   = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      out_spk_q <= '0;
      shadow_q  <= '0;
      spk_in_q  <= '0;
      for (int n = 0; n < N_OUT; n++) begin
        pot_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      out_spk_q <= out_spk_d;
      shadow_q  <= shadow_d;
      spk_in_q  <= spk_in_d;
      if (pot_we) begin
        pot_q[idx_q] <= new_pot;
      end
    end
  end

  assign out_spk = out_spk_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_snn_lif_layer.sv
// Scoreboard bench for snn_lif_layer: stimulus pushes expected spike vectors, monitors pop on done.
// A second instance with PW=12 covers potential saturation.
module tb_snn_lif_layer;

  logic        clk = 1'b0;
  logic        reset;
  logic        step;
  logic [15:0] in_signal;
  logic [14:0] thresh;
  logic        wt_we;
  logic [6:0]  wt_addr;
  logic [7:0]  wt_data;
  logic [7:0]  out_spk;
  logic        busy, done, overrun;

  logic        s_step;
  logic [10:0] s_thresh;
  logic        s_we;
  logic [6:0]  s_addr;
  logic [7:0]  s_data;
  logic [7:0]  s_out;
  logic        s_busy, s_done, s_ovr;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_s [$];
  logic [7:0] e_main, e_sat;

  always #5 clk = ~clk;

  snn_lif_layer dut (
    .clk(clk), .reset(reset), .step(step), .in_signal(in_signal), .thresh(thresh),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data), .out_spk(out_spk), .busy(busy),
    .done(done), .overrun(overrun)
  );

  snn_lif_layer #(.PW(12)) dut_s (
    .clk(clk), .reset(reset), .step(s_step), .in_signal(in_signal), .thresh(s_thresh),
    .wt_we(s_we), .wt_addr(s_addr), .wt_data(s_data), .out_spk(s_out), .busy(s_busy),
    .done(s_done), .overrun(s_ovr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_spk: unexpected done, got %0h expected none", out_spk);
      end else begin
        e_main = exp_q.pop_front();
        check("out_spk", {24'd0, out_spk}, {24'd0, e_main});
      end
    end
    if (s_done) begin
      if (exp_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sat_out_spk: unexpected done, got %0h expected none", s_out);
      end else begin
        e_sat = exp_s.pop_front();
        check("sat_out_spk", {24'd0, s_out}, {24'd0, e_sat});
      end
    end
  end

  task automatic write_all(input logic [7:0] val);
    for (int a = 0; a < 128; a++) begin
      @(negedge clk);
      wt_we = 1'b1; wt_addr = 7'(a); wt_data = val;
    end
    @(negedge clk);
    wt_we = 1'b0;
  endtask

  task automatic write_w(input int neuron, input int inp, input logic [7:0] val);
    @(negedge clk);
    wt_we = 1'b1; wt_addr = 7'(neuron * 16 + inp); wt_data = val;
    @(negedge clk);
    wt_we = 1'b0;
  endtask

  // race=1 writes w[3][0]=30 during the cycle neuron 3 is being updated.
  task automatic run_step(input logic [15:0] in, input logic [7:0] exp, input bit race,
                          output int lat);
    exp_q.push_back(exp);
    @(negedge clk);
    in_signal = in; step = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) step = 1'b0;
      if (race && lat == 4) begin
        wt_we = 1'b1; wt_addr = 7'd48; wt_data = 8'd30;
      end
      if (race && lat == 5) wt_we = 1'b0;
      if (done) break;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL step_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic run_step_s(input logic [7:0] exp);
    int n;
    exp_s.push_back(exp);
    @(negedge clk);
    in_signal = 16'hFFFF; s_step = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      s_step = 1'b0;
      if (s_done) break;
    end
    if (!s_done) begin
      checks++;
      errors++;
      $display("FAIL sat_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] integ_exp [8];
  int lat;
  int d0;

  initial begin
    reset = 1'b1; step = 1'b0; in_signal = '0; thresh = 15'd25;
    wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    s_step = 1'b0; s_thresh = '0; s_we = 1'b0; s_addr = '0; s_data = '0;
`ifdef SNN_REFRACTORY_EN
    integ_exp = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
`else
    integ_exp = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
`endif
    repeat (3) @(negedge clk);
    check("reset_out_spk", {24'd0, out_spk}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;

    // Mixed weights: inputs 2 and 5 active; neuron 4 sits exactly on threshold.
    write_all(8'h00);
    write_w(1, 2, 8'd20);
    write_w(1, 5, 8'd10);
    write_w(2, 2, 8'd40);
    write_w(2, 5, 8'hEC);
    write_w(4, 2, 8'd25);
    run_step(16'h0024, 8'h12, 1'b0, lat);
`ifdef SNN_REFRACTORY_EN
    run_step(16'h0024, 8'h04, 1'b0, lat);
    repeat (5) @(negedge clk);
    check("out_spk_stable", {24'd0, out_spk}, 32'h04);
`else
    run_step(16'h0024, 8'h16, 1'b0, lat);
    repeat (5) @(negedge clk);
    check("out_spk_stable", {24'd0, out_spk}, 32'h16);
`endif

    // Asynchronous reset in the middle of an update.
    @(negedge clk);
    in_signal = 16'h0024; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_out_spk", {24'd0, out_spk}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_step(16'h0000, 8'h00, 1'b0, lat);
    check("latency", lat, 32'd9);

    // Integration on neuron 0: potential 10, 20, 29 -> fire.
    pulse_reset();
    write_all(8'h00);
    write_w(0, 0, 8'd10);
    for (int s = 0; s < 8; s++) begin
      run_step(16'h0001, integ_exp[s], 1'b0, lat);
    end

    // Weight write racing neuron 3's update: old weight this step, new one next.
    pulse_reset();
    write_all(8'h00);
    run_step(16'h0001, 8'h00, 1'b1, lat);
    run_step(16'h0001, 8'h08, 1'b0, lat);

    // Overrun: second step while busy is dropped and the flag sticks.
    pulse_reset();
    check("overrun_clear", {31'd0, overrun}, 32'd0);
    d0 = done_cnt;
    exp_q.push_back(8'h08);
    @(negedge clk);
    in_signal = 16'h0001; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("overrun_set", {31'd0, overrun}, 32'd1);
    repeat (25) @(negedge clk);
    check("overrun_one_done", done_cnt - d0, 32'd1);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    pulse_reset();
    check("overrun_reset", {31'd0, overrun}, 32'd0);

    // Saturation on the PW=12 instance: neuron 0 clamps at -2048, zero-weight neurons fire at thresh 0.
    for (int a = 0; a < 128; a++) begin
      @(negedge clk);
      s_we = 1'b1; s_addr = 7'(a); s_data = (a < 16) ? 8'h80 : 8'h00;
    end
    @(negedge clk);
    s_we = 1'b0;
    run_step_s(8'hFE);
`ifdef SNN_REFRACTORY_EN
    run_step_s(8'h00);
`else
    run_step_s(8'hFE);
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size() + exp_s.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
